// File: rtl/updown_counter_gen2.sv
// Up/down counter with load, modulus, wrap/saturate and terminal-count pulse.
// Single clock domain; manual step input is synchronised and edge detected.
//
// Ports:
//   clk       in   1      system clock
//   rst       in   1      asynchronous reset, active high
//   run_mode  in   1      1 = advance on prescaler tick, 0 = on step edge
//   step_in   in   1      asynchronous step request, rising edge
//   enable    in   1      advance enable (load is not gated)
//   up_down   in   1      1 = count up, 0 = count down
//   load      in   1      synchronous load strobe
//   d_in      in   WIDTH  load value, clamped to MAX_COUNT
//   count     out  WIDTH  counter value (registered)
//   tc        out  1      one-cycle pulse when an advance hits a limit
module updown_counter_gen2 #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter bit               SATURATE  = 1'b0,
   parameter int               DIV       = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_mode,
   input  logic             step_in,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [PW-1:0]    r_pre;
   logic [WIDTH-1:0] r_count;
   logic             r_tc;

   logic             w_step;
   logic             w_tick;
   logic             w_adv;
   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_next;
   logic             w_next_tc;

   // Synchroniser resets high so a step held through reset is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
         r_s3 <= 1'b1;
      end else begin
         r_s1 <= step_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_step = r_s2 & ~r_s3;

   // Prescaler free-runs independent of enable and mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre <= '0;
      end else if (r_pre == P_LAST) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   assign w_tick = (r_pre == P_LAST);
   assign w_adv  = enable & (run_mode ? w_tick : w_step);

   assign w_at_max   = (r_count == MAX_COUNT);
   assign w_at_min   = (r_count == '0);
   assign w_load_val = (d_in > MAX_COUNT) ? MAX_COUNT : d_in;

   always_comb begin
      w_next    = r_count;
      w_next_tc = 1'b0;
      if (load) begin
         w_next = w_load_val;
      end else if (w_adv) begin
         if (up_down) begin
            if (w_at_max) begin
               w_next_tc = 1'b1;
               w_next    = SATURATE ? r_count : '0;
            end else begin
               w_next = r_count + WIDTH'(1);
            end
         end else begin
            if (w_at_min) begin
               w_next_tc = 1'b1;
               w_next    = SATURATE ? r_count : MAX_COUNT;
            end else begin
               w_next = r_count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_next_tc;
      end
   end

   assign count = r_count;
   assign tc    = r_tc;

endmodule

// File: tb/tb_updown_counter_gen2.sv
// Scoreboard bench for updown_counter_gen2: three configurations share
// stimulus; a reference model predicts each edge, a monitor compares.
module tb_updown_counter_gen2;

   localparam int N = 3;
   localparam int MX [N] = '{15, 9, 9};
   localparam int SA [N] = '{0, 1, 0};
   localparam int DV [N] = '{1, 5, 3};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run_mode = 1'b0;
   logic       step_in = 1'b0;
   logic       enable = 1'b0;
   logic       up_down = 1'b1;
   logic       load = 1'b0;
   logic [3:0] d_in = '0;
   logic [3:0] dc [N];
   logic       dt [N];

   typedef struct packed {
      logic [N-1:0][3:0] c;
      logic [N-1:0]      t;
   } exp_t;

   exp_t q [$];
   int total = 0;
   int bad = 0;

   int mc [N];
   bit mt [N];
   int k = 0;
   bit h1 = 1, h2 = 1, h3 = 1;

   always #5 clk = ~clk;

   updown_counter_gen2 #(
      .WIDTH(4), .MAX_COUNT(4'd15), .SATURATE(1'b0), .DIV(1)
   ) u0 (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step_in(step_in),
      .enable(enable), .up_down(up_down), .load(load), .d_in(d_in),
      .count(dc[0]), .tc(dt[0])
   );

   updown_counter_gen2 #(
      .WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1), .DIV(5)
   ) u1 (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step_in(step_in),
      .enable(enable), .up_down(up_down), .load(load), .d_in(d_in),
      .count(dc[1]), .tc(dt[1])
   );

   updown_counter_gen2 #(
      .WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0), .DIV(3)
   ) u2 (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step_in(step_in),
      .enable(enable), .up_down(up_down), .load(load), .d_in(d_in),
      .count(dc[2]), .tc(dt[2])
   );

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // Predict the state after the coming rising edge from current inputs.
   task automatic model_edge();
      exp_t e;
      bit pulse, tick, adv;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mc[i] = 0;
            mt[i] = 0;
         end
         k = 0;
         h1 = 1; h2 = 1; h3 = 1;
      end else begin
         // A step is seen two edges after the first high sample.
         pulse = h2 & ~h3;
         for (int i = 0; i < N; i++) begin
            tick = ((k % DV[i]) == DV[i] - 1);
            adv = enable && (run_mode ? tick : pulse);
            mt[i] = 0;
            if (load) begin
               mc[i] = (int'(d_in) > MX[i]) ? MX[i] : int'(d_in);
            end else if (adv && up_down) begin
               if (mc[i] == MX[i]) begin
                  mt[i] = 1;
                  mc[i] = SA[i] ? mc[i] : 0;
               end else mc[i] = mc[i] + 1;
            end else if (adv) begin
               if (mc[i] == 0) begin
                  mt[i] = 1;
                  mc[i] = SA[i] ? 0 : MX[i];
               end else mc[i] = mc[i] - 1;
            end
         end
         h3 = h2; h2 = h1; h1 = step_in;
         k++;
      end
      for (int i = 0; i < N; i++) begin
         e.c[i] = 4'(mc[i]);
         e.t[i] = mt[i];
      end
      q.push_back(e);
   endtask

   task automatic cyc(input bit r, input bit rm, input bit st,
                      input bit en, input bit ud, input bit ld,
                      input logic [3:0] d);
      bit was_rst;
      @(negedge clk);
      was_rst = rst;
      rst = r; run_mode = rm; step_in = st;
      enable = en; up_down = ud; load = ld; d_in = d;
      model_edge();
      if (r && !was_rst) begin
         #1;
         for (int i = 0; i < N; i++) begin
            chk($sformatf("async_rst_count%0d", i), int'(dc[i]), 0);
            chk($sformatf("async_rst_tc%0d", i), int'(dt[i]), 0);
         end
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares every post-edge output against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < N; i++) begin
               chk($sformatf("sb_count%0d", i), int'(dc[i]), int'(e.c[i]));
               chk($sformatf("sb_tc%0d", i), int'(dt[i]), int'(e.t[i]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] s0, s1, s2;
      bit st, rm, ud;
      // Reset and defaults counting up.
      cyc(1, 1, 0, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, 1, 0, 0);
      settle();
      chk("t1_wrap_count0", int'(dc[0]), 0);
      chk("t1_wrap_tc0", int'(dt[0]), 1);
      chk("t1_div5_count1", int'(dc[1]), 3);
      chk("t1_div3_count2", int'(dc[2]), 5);
      // Saturating count down from 2, then clamped load.
      cyc(0, 1, 0, 1, 0, 1, 2);
      for (int i = 0; i < 22; i++) cyc(0, 1, 0, 1, 0, 0, 0);
      settle();
      chk("t2_sat_hold1", int'(dc[1]), 0);
      cyc(0, 1, 0, 0, 0, 1, 12);
      settle();
      chk("t2_clamp1", int'(dc[1]), 9);
      chk("t2_noclamp0", int'(dc[0]), 12);
      // Manual step held high for 20 cycles.
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0, 0);
      settle();
      s0 = dc[0];
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 1, 0, 0);
      settle();
      chk("t3_single_step0", int'(dc[0]), int'(s0 + 4'd1));
      // Free-run ignores step toggles.
      for (int i = 0; i < 20; i++) cyc(0, 1, i[0], 1, 1, 0, 0);
      // Enable low: counts frozen.
      settle();
      s0 = dc[0]; s1 = dc[1]; s2 = dc[2];
      for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 1, 0, 0);
      settle();
      chk("t4_frozen0", int'(dc[0]), int'(s0));
      chk("t4_frozen1", int'(dc[1]), int'(s1));
      chk("t4_frozen2", int'(dc[2]), int'(s2));
      for (int i = 0; i < 12; i++) cyc(0, 1, 0, 1, 1, 0, 0);
      // Load beats a coincident advance; load ignores enable.
      cyc(0, 1, 0, 1, 1, 1, 6);
      settle();
      chk("t5_load_adv0", int'(dc[0]), 6);
      chk("t5_load_tc0", int'(dt[0]), 0);
      cyc(0, 1, 0, 0, 1, 1, 3);
      settle();
      chk("t5_load_noen0", int'(dc[0]), 3);
      // Reset with step held high; no step until a fresh edge.
      cyc(0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0, 0);
      cyc(1, 0, 1, 1, 1, 0, 0);
      cyc(1, 0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 1, 0, 0);
      settle();
      chk("t6_no_step0", int'(dc[0]), 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1, 0, 0);
      settle();
      chk("t6_new_step0", int'(dc[0]), 1);
      // Randomised traffic.
      st = 0; rm = 1; ud = 1;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(3) == 0) st = ~st;
         if ($urandom_range(31) == 0) rm = ~rm;
         if ($urandom_range(7) == 0) ud = ~ud;
         if ($urandom_range(299) == 0) begin
            cyc(1, rm, 1, 1, ud, 0, 0);
            cyc(0, rm, 1, 1, ud, 0, 0);
         end else begin
            cyc(0, rm, st, ($urandom_range(7) != 0), ud,
                ($urandom_range(15) == 0), 4'($urandom_range(15)));
         end
      end
      settle();
      settle();
      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
